// File: rtl/hex_pair_scroll_ctrl.sv
// Avalon-MM controller for the HEX5/HEX4 digit pair: holds an 8-nibble message
// and scrolls or blinks a two-digit window over it at a programmable rate.
module hex_pair_scroll_ctrl #(
  parameter int NUM_CHARS  = 8,
  parameter int PRESCALE_W = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] out_port
);

  localparam logic [2:0] LAST = 3'(NUM_CHARS - 1);

  logic [2:0]            ctrl;
  logic [31:0]           data;
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] per_m1;
  logic [2:0]            pos;
  logic [2:0]            pos_nx;
  logic                  blank;
  logic                  wr, wr_ctrl, wr_data, wr_per, restart;
  logic                  tick;
  logic [3:0]            nib_lo, nib_hi;
  logic [15:0]           disp;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == 2'd0);
  assign wr_data = wr && (address == 2'd1);
  assign wr_per  = wr && (address == 2'd2);
  assign restart = wr && (address == 2'd3);

  // PERIOD=0 is treated as 1, so the terminal count is 0 in both cases
  assign per_m1 = (period == '0) ? '0 : period - PRESCALE_W'(1);
  assign tick   = ctrl[0] && (cnt == per_m1) && !wr_per && !restart;
  assign pos_nx = (pos == LAST) ? 3'd0 : pos + 3'd1;

  assign nib_lo = data[{pos, 2'b00} +: 4];
  assign nib_hi = data[{pos_nx, 2'b00} +: 4];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    disp = 16'hFFFF;
    if (ctrl[0] && !blank) disp = {1'b1, seg7(nib_hi), 1'b1, seg7(nib_lo)};
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {29'b0, ctrl};
      2'd1:    readdata = data;
      2'd2:    readdata = 32'(period);
      default: readdata = {28'b0, blank, pos};
    endcase
  end

  // tick is derived from the pre-write CTRL bits, so a coincident CTRL write
  // only takes effect from the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      data     <= '0;
      period   <= '0;
      cnt      <= '0;
      pos      <= '0;
      blank    <= 1'b0;
      out_port <= 16'hFFFF;
    end else begin
      if (wr_ctrl) ctrl   <= writedata[2:0];
      if (wr_data) data   <= writedata;
      if (wr_per)  period <= writedata[PRESCALE_W-1:0];

      if (wr_per || restart) cnt <= '0;
      else if (ctrl[0])      cnt <= tick ? '0 : cnt + PRESCALE_W'(1);

      if (restart)              pos <= '0;
      else if (tick && ctrl[1]) pos <= pos_nx;

      if (restart || (wr_ctrl && !writedata[2])) blank <= 1'b0;
      else if (tick && ctrl[2])                  blank <= ~blank;

      out_port <= disp;
    end
  end

endmodule

// File: tb/tb_hex_pair_scroll_ctrl.sv
// Directed bench for hex_pair_scroll_ctrl: an 8-char build plus a 5-char build
// sharing one bus, checked against hand-computed glyph and position values.
module tb_hex_pair_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata5;
  logic [15:0] out_port, out_port5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_pair_scroll_ctrl #(.NUM_CHARS(8), .PRESCALE_W(26)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  hex_pair_scroll_ctrl #(.NUM_CHARS(5), .PRESCALE_W(26)) dut5 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata5), .out_port(out_port5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called at a negedge; the write lands on the next posedge, returns at the following negedge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  logic [15:0] blink_exp [5];

  initial begin
    blink_exp[0] = 16'hF9C0; blink_exp[1] = 16'hF9C0;
    blink_exp[2] = 16'hFFFF; blink_exp[3] = 16'hFFFF;
    blink_exp[4] = 16'hF9C0;

    // 1: reset, with writes that must be ignored
    repeat (2) @(negedge clk);
    wr(2'd0, 32'h7);
    wr(2'd1, 32'h12345678);
    wr(2'd2, 32'h5);
    wr(2'd3, 32'h0);
    reset = 1'b0;
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_data", 2'd1, 32'h0);
    rd("rst_period", 2'd2, 32'h0);
    rd("rst_status", 2'd3, 32'h0);
    chk("rst_out", 32'(out_port), 32'h0000FFFF);

    // 2: static display, one cycle of decode latency
    wr(2'd1, 32'h00000012);
    wr(2'd0, 32'h1);
    chk("t2_out_lat", 32'(out_port), 32'h0000FFFF);
    @(negedge clk);
    chk("t2_out", 32'(out_port), 32'h0000F9A4);
    repeat (10) @(negedge clk);
    rd("t2_pos", 2'd3, 32'h0);
    chk("t2_out_hold", 32'(out_port), 32'h0000F9A4);

    // 3: scroll every 3 clocks through 8 chars and wrap
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h76543210);
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h0);
    wr(2'd0, 32'hFFFF_FFFB);
    rd("t3_ctrl_rb", 2'd0, 32'h3);
    for (int k = 1; k < 8; k++) begin
      repeat (3) @(negedge clk);
      rd($sformatf("t3_pos%0d", k), 2'd3, 32'(k));
      if (k == 4) chk("t3_out_pos3", 32'(out_port), 32'h000099B0);
    end
    @(negedge clk);
    chk("t3_out_pos7", 32'(out_port), 32'h0000C0F8);
    repeat (2) @(negedge clk);
    rd("t3_wrap", 2'd3, 32'h0);

    // 4: blink every 2 clocks, then clear blink while blanked
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h2);
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_blink%0d", i + 1), 32'(out_port), 32'(blink_exp[i]));
    end
    @(negedge clk);
    rd("t4_status_blank", 2'd3, 32'h8);
    wr(2'd0, 32'h1);
    rd("t4_blank_clr", 2'd3, 32'h0);
    chk("t4_out_lag", 32'(out_port), 32'h0000FFFF);
    @(negedge clk);
    chk("t4_out_back", 32'(out_port), 32'h0000F9C0);

    // 5: restart coincident with a tick
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h3);
    repeat (3) @(negedge clk);
    rd("t5_pos1", 2'd3, 32'h1);
    repeat (2) @(negedge clk);
    wr(2'd3, 32'h0);
    rd("t5_restart", 2'd3, 32'h0);
    repeat (2) @(negedge clk);
    rd("t5_cnt_clr", 2'd3, 32'h0);
    @(negedge clk);
    rd("t5_next_tick", 2'd3, 32'h1);

    // 6: PERIOD=0 ticks every clock; 5-char build wraps 4->0
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rd($sformatf("t6_pos%0d", k), 2'd3, 32'(k));
      chk($sformatf("t6_pos5_%0d", k), readdata5, 32'(k % 5));
    end
    chk("t6_out8", 32'(out_port), 32'h00009299);
    chk("t6_out5", 32'(out_port5), 32'h0000C099);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
